// File: rtl/mac_row_collector_pkg.sv
// mac_row_collector_pkg
//   Shared constants, types and helpers for the MAC row collector.
//   PSUM_BW          width of one partial sum (signed two's complement)
//   COL              number of columns, one FIFO per column
//   COLLECTOR_DEPTH  entries per column FIFO (power of two, >= 2)
package mac_row_collector_pkg;

    localparam int PSUM_BW         = 16;
    localparam int COL             = 8;
    localparam int COLLECTOR_DEPTH = 64;

    typedef logic signed [PSUM_BW-1:0]     psum_t;
    typedef logic        [PSUM_BW*COL-1:0] row_t;

    // Negative partial sums clamp to zero; non-negative ones pass through.
    function automatic psum_t relu(input psum_t v);
        return v[PSUM_BW-1] ? '0 : v;
    endfunction

endpackage

// File: rtl/mac_row_collector_col_fifo.sv
// mac_row_collector_col_fifo
//   Single-column synchronous FIFO holding the partial sums of one MAC column.
//   Ports:
//     clk    rising-edge clock
//     reset  asynchronous active-low reset (pointers only; storage is not cleared)
//     wr     capture request; honoured when not full, or when full and popped
//            on the same edge (the pop frees the slot)
//     pop    remove the head entry; the caller only pops a non-empty FIFO
//     din    data to capture
//     dout   head entry, combinational
//     empty  no entries stored
//     full   DEPTH entries stored
module mac_row_collector_col_fifo
    import mac_row_collector_pkg::*;
#(
    parameter int DEPTH = COLLECTOR_DEPTH
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  wr,
    input  logic  pop,
    input  psum_t din,
    output psum_t dout,
    output logic  empty,
    output logic  full
);

    localparam int AW = $clog2(DEPTH);

    // One extra pointer bit distinguishes full from empty when the
    // index bits match.
    logic [AW:0] wptr_q, wptr_d;
    logic [AW:0] rptr_q, rptr_d;
    psum_t       mem_q [DEPTH];
    logic        do_wr;

    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[AW] != rptr_q[AW]) &&
                   (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign do_wr = wr && (!full || pop);
    assign dout  = mem_q[rptr_q[AW-1:0]];

    always_comb begin
        wptr_d = wptr_q + {{AW{1'b0}}, do_wr};
        rptr_d = rptr_q + {{AW{1'b0}}, pop};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wptr_q[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/mac_row_collector.sv
// mac_row_collector
//   South-end receiver for a MAC row. Each column's partial sum is captured
//   into its own FIFO when that column's valid bit fires (columns arrive
//   skewed by one cycle each). A full row is released only once every
//   column holds at least one entry.
//   Ports:
//     clk       rising-edge clock
//     reset     asynchronous active-low reset
//     in        psum bus, column c at [PSUM_BW*(c+1)-1 : PSUM_BW*c]
//     wr        per-column capture strobe
//     rd        pop request for one full row
//     out       registered popped row, same packing as in
//     o_valid   every column non-empty (row poppable)
//     o_full    any column full
//     o_empty   all columns empty
//     overflow  sticky: a write hit a full column that was not popped
//   Configuration macro:
//     MAC_ROW_COLLECTOR_RELU_EN  clamp negative slices to zero on pop
module mac_row_collector
    import mac_row_collector_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    input  row_t           in,
    input  logic [COL-1:0] wr,
    input  logic           rd,
    output row_t           out,
    output logic           o_valid,
    output logic           o_full,
    output logic           o_empty,
    output logic           overflow
);

    psum_t          head [COL];
    logic [COL-1:0] empty_v;
    logic [COL-1:0] full_v;
    logic           pop;

    row_t out_q, out_d;
    logic overflow_q, overflow_d;

    for (genvar c = 0; c < COL; c++) begin : g_col
        mac_row_collector_col_fifo #(
            .DEPTH (COLLECTOR_DEPTH)
        ) u_col_fifo (
            .clk   (clk),
            .reset (reset),
            .wr    (wr[c]),
            .pop   (pop),
            .din   (in[c*PSUM_BW +: PSUM_BW]),
            .dout  (head[c]),
            .empty (empty_v[c]),
            .full  (full_v[c])
        );
    end

    assign o_valid = ~|empty_v;
    assign o_empty = &empty_v;
    assign o_full  = |full_v;

    // All columns pop together, and only when every column has data.
    assign pop = rd && o_valid;

    always_comb begin
        out_d = out_q;
        if (pop) begin
            for (int c = 0; c < COL; c++) begin
`ifdef MAC_ROW_COLLECTOR_RELU_EN
                out_d[c*PSUM_BW +: PSUM_BW] = relu(head[c]);
`else
                out_d[c*PSUM_BW +: PSUM_BW] = head[c];
`endif
            end
        end
    end

    // A write to a full column is lost unless the same-edge pop frees a slot.
    always_comb begin
        overflow_d = overflow_q | (|(wr & full_v & ~{COL{pop}}));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            out_q      <= out_d;
            overflow_q <= overflow_d;
        end
    end

    assign out      = out_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_mac_row_collector.sv
// tb_mac_row_collector
//   Self-checking bench for mac_row_collector: a table-driven skewed fill,
//   hand-written multi-cycle sequences (partial row, full/overflow,
//   full with simultaneous pop across pointer wrap, async reset, ReLU
//   slice), and random traffic checked against a queue-based model.
//   Honours MAC_ROW_COLLECTOR_RELU_EN for the expected popped data.
module tb_mac_row_collector;
    import mac_row_collector_pkg::*;

    localparam int ROW_W = PSUM_BW * COL;
    localparam int DEPTH = COLLECTOR_DEPTH;

    // ---------------- clock / reset ----------------
    logic           clk = 1'b0;
    logic           reset;
    row_t           in;
    logic [COL-1:0] wr;
    logic           rd;
    row_t           out;
    logic           o_valid;
    logic           o_full;
    logic           o_empty;
    logic           overflow;

    always #5 clk = ~clk;

    mac_row_collector dut (
        .clk      (clk),
        .reset    (reset),
        .in       (in),
        .wr       (wr),
        .rd       (rd),
        .out      (out),
        .o_valid  (o_valid),
        .o_full   (o_full),
        .o_empty  (o_empty),
        .overflow (overflow)
    );

    // ---------------- scoreboard / model state ----------------
    int total = 0;
    int bad   = 0;

    logic [15:0]      mq [COL][$];   // per-column stored entries
    logic [ROW_W-1:0] exp_q [$];     // rows the model expects to appear on out
    logic [ROW_W-1:0] m_out;
    logic             m_ovf;

    typedef struct {
        logic [COL-1:0] w;
        logic           r;
        logic           ev;
        logic           ee;
        logic           ef;
        logic [ROW_W-1:0] eo;
    } vec_t;

    vec_t tbl [9];

    function automatic logic [15:0] ref_relu(input logic [15:0] v);
`ifdef MAC_ROW_COLLECTOR_RELU_EN
        return v[15] ? 16'h0000 : v;
`else
        return v;
`endif
    endfunction

    function automatic logic [ROW_W-1:0] skew_row(input logic [15:0] base);
        logic [ROW_W-1:0] r;
        for (int c = 0; c < COL; c++) r[c*16 +: 16] = base + 16'(c);
        return r;
    endfunction

    function automatic logic [ROW_W-1:0] idx_row(input int i);
        logic [ROW_W-1:0] r;
        for (int c = 0; c < COL; c++) r[c*16 +: 16] = {8'(i), 8'(c)};
        return r;
    endfunction

    task automatic check(input string name, input logic [ROW_W-1:0] act,
                         input logic [ROW_W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int c = 0; c < COL; c++) mq[c].delete();
        exp_q.delete();
        m_out = '0;
        m_ovf = 1'b0;
    endtask

    // One clock edge of the model: pop (if every column has data) first,
    // then pushes; a push into a column still at DEPTH entries is lost.
    task automatic model_edge(input logic [COL-1:0] w, input logic [ROW_W-1:0] d,
                              input logic r);
        bit all_ne;
        logic [ROW_W-1:0] row;
        all_ne = 1'b1;
        row    = '0;
        for (int c = 0; c < COL; c++) if (mq[c].size() == 0) all_ne = 1'b0;
        if (r && all_ne) begin
            for (int c = 0; c < COL; c++) row[c*16 +: 16] = ref_relu(mq[c].pop_front());
            exp_q.push_back(row);
        end
        for (int c = 0; c < COL; c++) begin
            if (w[c]) begin
                if (mq[c].size() < DEPTH) mq[c].push_back(d[c*16 +: 16]);
                else                      m_ovf = 1'b1;
            end
        end
    endtask

    task automatic check_model(input string name);
        bit ne_all;
        bit e_all;
        bit f_any;
        ne_all = 1'b1;
        e_all  = 1'b1;
        f_any  = 1'b0;
        for (int c = 0; c < COL; c++) begin
            if (mq[c].size() == 0) ne_all = 1'b0;
            else                   e_all  = 1'b0;
            if (mq[c].size() == DEPTH) f_any = 1'b1;
        end
        while (exp_q.size() > 0) m_out = exp_q.pop_front();
        check({name, ".out"},      out,              m_out);
        check({name, ".valid"},    ROW_W'(o_valid),  ROW_W'(ne_all));
        check({name, ".empty"},    ROW_W'(o_empty),  ROW_W'(e_all));
        check({name, ".full"},     ROW_W'(o_full),   ROW_W'(f_any));
        check({name, ".overflow"}, ROW_W'(overflow), ROW_W'(m_ovf));
    endtask

    // ---------------- driver tasks ----------------
    task automatic step(input logic [COL-1:0] w, input logic [ROW_W-1:0] d,
                        input logic r, input string name);
        wr = w;
        in = d;
        rd = r;
        @(posedge clk);
        model_edge(w, d, r);
        #1;
        check_model(name);
    endtask

    task automatic reset_dut();
        wr    = '0;
        rd    = 1'b0;
        in    = '0;
        reset = 1'b0;
        model_clear();
        @(posedge clk);
        #1;
        check_model("reset");
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic run_table(input string tag);
        for (int k = 0; k < 9; k++) begin
            step(tbl[k].w, skew_row(16'h0100), tbl[k].r, tag);
            check({tag, ".tbl_valid"}, ROW_W'(o_valid), ROW_W'(tbl[k].ev));
            check({tag, ".tbl_empty"}, ROW_W'(o_empty), ROW_W'(tbl[k].ee));
            check({tag, ".tbl_full"},  ROW_W'(o_full),  ROW_W'(tbl[k].ef));
            check({tag, ".tbl_out"},   out,             tbl[k].eo);
        end
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [ROW_W-1:0] held;
        logic [ROW_W-1:0] rrow;

        for (int k = 0; k < 8; k++) begin
            tbl[k] = '{w: 8'(1 << k), r: 1'b0, ev: (k == 7), ee: 1'b0, ef: 1'b0, eo: '0};
        end
        tbl[8] = '{w: '0, r: 1'b1, ev: 1'b0, ee: 1'b1, ef: 1'b0, eo: skew_row(16'h0100)};

        // Skewed fill and single pop.
        reset_dut();
        run_table("skew");

        // Partial row: column 7 missing, pops are ignored.
        reset_dut();
        for (int c = 0; c < 7; c++) step(8'(1 << c), skew_row(16'h0200), 1'b0, "part_fill");
        repeat (5) begin
            step('0, '0, 1'b1, "part_rd");
            check("part_out_zero", out, '0);
            check("part_valid0", ROW_W'(o_valid), '0);
        end
        step(8'h80, skew_row(16'h0200), 1'b0, "part_col7");
        step('0, '0, 1'b1, "part_pop");
        check("part_pop_out", out, skew_row(16'h0200));
        step('0, '0, 1'b1, "part_pop2");
        check("part_hold_out", out, skew_row(16'h0200));
        check("part_empty", ROW_W'(o_empty), ROW_W'(1));

        // Full and overflow.
        reset_dut();
        for (int i = 0; i < DEPTH; i++) step(8'hFF, idx_row(i), 1'b0, "full_fill");
        step(8'hFF, {COL{16'hDEAD}}, 1'b0, "full_ovf");
        check("ovf_full", ROW_W'(o_full), ROW_W'(1));
        check("ovf_flag", ROW_W'(overflow), ROW_W'(1));
        for (int i = 0; i < DEPTH; i++) begin
            step('0, '0, 1'b1, "full_drain");
            check("full_order", out, idx_row(i));
        end
        check("full_drained_empty", ROW_W'(o_empty), ROW_W'(1));

        // Full with simultaneous pop, across a pointer wrap.
        reset_dut();
        for (int i = 0; i < 32; i++) step(8'hFF, idx_row(i), 1'b0, "wrap_pre");
        for (int i = 0; i < 32; i++) step('0, '0, 1'b1, "wrap_prepop");
        for (int i = 0; i < DEPTH; i++) step(8'hFF, idx_row(i + 100), 1'b0, "wrap_fill");
        check("wrap_full", ROW_W'(o_full), ROW_W'(1));
        step(8'hFF, idx_row(200), 1'b1, "wrap_wrpop");
        check("wrap_no_ovf", ROW_W'(overflow), ROW_W'(0));
        check("wrap_still_full", ROW_W'(o_full), ROW_W'(1));
        check("wrap_first", out, idx_row(100));
        for (int i = 1; i <= DEPTH; i++) begin
            step('0, '0, 1'b1, "wrap_drain");
            check("wrap_order", out, (i < DEPTH) ? idx_row(i + 100) : idx_row(200));
        end
        check("wrap_empty", ROW_W'(o_empty), ROW_W'(1));

        // Asynchronous reset mid-stream.
        reset_dut();
        for (int i = 0; i < 10; i++) step(8'hFF, idx_row(i + 20), 1'b0, "ar_fill");
        step('0, '0, 1'b1, "ar_pop");
        reset = 1'b0;
        #2;
        check("ar_empty", ROW_W'(o_empty), ROW_W'(1));
        check("ar_valid", ROW_W'(o_valid), ROW_W'(0));
        check("ar_out", out, '0);
        check("ar_ovf", ROW_W'(overflow), ROW_W'(0));
        model_clear();
        #2;
        reset = 1'b1;
        @(posedge clk);
        #1;
        run_table("ar_skew");

        // ReLU slice check.
        reset_dut();
        rrow = skew_row(16'h0000);
        rrow[3*16 +: 16] = 16'hFFF0;
        rrow[4*16 +: 16] = 16'h0010;
        step(8'hFF, rrow, 1'b0, "relu_wr");
        step('0, '0, 1'b1, "relu_pop");
        held = out;
`ifdef MAC_ROW_COLLECTOR_RELU_EN
        check("relu_s3", ROW_W'(held[3*16 +: 16]), ROW_W'(16'h0000));
`else
        check("relu_s3", ROW_W'(held[3*16 +: 16]), ROW_W'(16'hFFF0));
`endif
        check("relu_s4", ROW_W'(held[4*16 +: 16]), ROW_W'(16'h0010));

        // Random traffic: a fill-heavy phase (reaches full/overflow) then a drain-heavy one.
        reset_dut();
        for (int n = 0; n < 500; n++) begin
            logic [COL-1:0]   w;
            logic [ROW_W-1:0] d;
            logic             r;
            w = 8'($urandom_range(0, 255));
            d = {$urandom, $urandom, $urandom, $urandom};
            if (n < 250) r = ($urandom_range(0, 7) == 0);
            else         r = ($urandom_range(0, 3) != 0);
            step(w, d, r, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
